// File: rtl/io_seq_pkg.sv
// Shared types and OB code decode for the slow-output character sequencer.
package io_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    STROBE,
    WAIT_DEV,
    CLEAR,
    DONE,
    CLEAR_ABORT
  } seq_state_e;

  // OB bit 3 is a don't-care for both control codes.
  localparam logic [4:0] STOP_MASK = 5'b10111;
  localparam logic [4:0] STOP_VAL  = 5'b00100;
  localparam logic [4:0] WAIT_MASK = 5'b10111;
  localparam logic [4:0] WAIT_VAL  = 5'b00111;

  function automatic logic is_stop(input logic [4:0] code);
    return (code & STOP_MASK) == STOP_VAL;
  endfunction

  function automatic logic is_wait(input logic [4:0] code);
    return (code & WAIT_MASK) == WAIT_VAL;
  endfunction

endpackage

// File: rtl/io_slow_out_seq_if.sv
// OB datapath handshake and device adapter signals of the slow-output sequencer.
interface io_slow_out_seq_if;
  logic       char_req;
  logic       char_ack;
  logic [4:0] ob_code;
  logic       ob_clear;
  logic [4:0] dev_code;
  logic       dev_strobe_tw;
  logic       dev_strobe_pn;
  logic       dev_busy;

  modport master (
    output char_req, ob_clear, dev_code, dev_strobe_tw, dev_strobe_pn,
    input  char_ack, ob_code, dev_busy
  );

  modport slave (
    input  char_req, ob_clear, dev_code, dev_strobe_tw, dev_strobe_pn,
    output char_ack, ob_code, dev_busy
  );
endinterface

// File: rtl/io_cycle_timer.sv
// Loadable down-counter shared by the strobe, settle and ack-timeout phases.
// expired is high while the count sits at zero.
module io_cycle_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         expired
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over decrement; hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/io_slow_out_seq.sv
// Slow-output character sequencer: pulls characters through OB, decodes
// STOP/WAIT, strobes the selected device and waits for it to settle.
module io_slow_out_seq
  import io_seq_pkg::*;
#(
  parameter int STROBE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic               CLOCK,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               dev_sel,
  io_slow_out_seq_if.master  io,
  output logic               ready,
  output logic               word_done,
  output logic               err_timeout,
  output logic [5:0]         char_cnt
);

  localparam int MAX_A   = (TIMEOUT > STROBE_CYCLES) ? TIMEOUT : STROBE_CYCLES;
  localparam int MAX_CYC = (MAX_A > SETTLE_CYCLES) ? MAX_A : SETTLE_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  // The timer holds "cycles remaining minus one". The char_req cycle is the
  // first of the TIMEOUT cycles, hence the extra minus one on the ack wait.
  localparam logic [TW-1:0] TMO_LD = TW'(TIMEOUT - 2);
  localparam logic [TW-1:0] STB_LD = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] SET_LD = TW'(SETTLE_CYCLES - 1);

  seq_state_e state_q, state_d;
  logic       sel_q, sel_d;
  logic [4:0] code_q, code_d;
  logic [5:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       req_q, req_d;
  logic       clr_q, clr_d;
  logic       done_q, done_d;
  logic       rdy_q, rdy_d;
  logic       stw_q, stw_d;
  logic       spn_q, spn_d;

  logic          tmr_load;
  logic          tmr_en;
  logic [TW-1:0] tmr_val;
  logic          tmr_exp;

  io_cycle_timer #(.W(TW)) u_timer (
    .clk     (CLOCK),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_val),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  // Next-state, latches and timer control; abort overrides every busy state.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    code_d   = code_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    tmr_val  = '0;
    if ((state_q != IDLE) && abort) begin
      state_d = CLEAR_ABORT;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_d = REQ;
            sel_d   = dev_sel;
            cnt_d   = '0;
            err_d   = 1'b0;
          end
        end
        REQ: begin
          tmr_load = 1'b1;
          tmr_val  = TMO_LD;
          state_d  = WAIT_ACK;
        end
        WAIT_ACK: begin
          if (io.char_ack) begin
            code_d = io.ob_code;
            if (is_stop(io.ob_code)) begin
              state_d = DONE;
            end else if (is_wait(io.ob_code)) begin
              state_d = CLEAR;
            end else begin
              state_d  = STROBE;
              tmr_load = 1'b1;
              tmr_val  = STB_LD;
              cnt_d    = cnt_q + 6'd1;
            end
          end else if (tmr_exp) begin
            err_d   = 1'b1;
            state_d = CLEAR_ABORT;
          end else begin
            tmr_en = 1'b1;
          end
        end
        STROBE: begin
          if (tmr_exp) begin
            state_d  = WAIT_DEV;
            tmr_load = 1'b1;
            tmr_val  = SET_LD;
          end else begin
            tmr_en = 1'b1;
          end
        end
        WAIT_DEV: begin
          if (io.dev_busy) begin
            tmr_load = 1'b1;
            tmr_val  = SET_LD;
          end else if (tmr_exp) begin
            state_d = CLEAR;
          end else begin
            tmr_en = 1'b1;
          end
        end
        CLEAR:       state_d = REQ;
        DONE:        state_d = IDLE;
        CLEAR_ABORT: state_d = IDLE;
        default:     state_d = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    req_d  = (state_d == REQ);
    clr_d  = (state_d inside {CLEAR, DONE, CLEAR_ABORT});
    done_d = (state_d == DONE);
    rdy_d  = (state_d == IDLE);
    stw_d  = (state_d == STROBE) && !sel_d;
    spn_d  = (state_d == STROBE) && sel_d;
  end

  // State, latches and registered outputs.
  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      code_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      clr_q   <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
      stw_q   <= 1'b0;
      spn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      req_q   <= req_d;
      clr_q   <= clr_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      stw_q   <= stw_d;
      spn_q   <= spn_d;
    end
  end

  assign io.char_req      = req_q;
  assign io.ob_clear      = clr_q;
  assign io.dev_code      = code_q;
  assign io.dev_strobe_tw = stw_q;
  assign io.dev_strobe_pn = spn_q;
  assign ready            = rdy_q;
  assign word_done        = done_q;
  assign err_timeout      = err_q;
  assign char_cnt         = cnt_q;

endmodule

// File: tb/tb_io_slow_out_seq.sv
// Directed bench for the slow-output character sequencer.
module tb_io_slow_out_seq;

  localparam int STB = 4;
  localparam int SET = 2;
  localparam int TMO = 1024;

  localparam logic [4:0] C_STOP  = 5'b00100;
  localparam logic [4:0] C_STOP3 = 5'b01100;
  localparam logic [4:0] C_WAIT  = 5'b00111;

  logic       CLOCK = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       dev_sel;
  logic       ready;
  logic       word_done;
  logic       err_timeout;
  logic [5:0] char_cnt;

  always #5 CLOCK = ~CLOCK;

  io_slow_out_seq_if ifc ();

  io_slow_out_seq #(
    .STROBE_CYCLES (STB),
    .SETTLE_CYCLES (SET),
    .TIMEOUT       (TMO)
  ) dut (
    .CLOCK       (CLOCK),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .dev_sel     (dev_sel),
    .io          (ifc),
    .ready       (ready),
    .word_done   (word_done),
    .err_timeout (err_timeout),
    .char_cnt    (char_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Activity monitor, sampled mid-cycle.
  int         tw_hi = 0, tw_rise = 0, pn_hi = 0, pn_rise = 0, clr_n = 0, wd_n = 0;
  int         log_n = 0;
  logic       prev_tw = 1'b0, prev_pn = 1'b0;
  logic [4:0] code_log [64];

  always @(negedge CLOCK) begin
    prev_tw <= ifc.dev_strobe_tw;
    prev_pn <= ifc.dev_strobe_pn;
    if (ifc.dev_strobe_tw) tw_hi <= tw_hi + 1;
    if (ifc.dev_strobe_pn) pn_hi <= pn_hi + 1;
    if (ifc.dev_strobe_tw && !prev_tw) tw_rise <= tw_rise + 1;
    if (ifc.dev_strobe_pn && !prev_pn) pn_rise <= pn_rise + 1;
    if ((ifc.dev_strobe_tw && !prev_tw) || (ifc.dev_strobe_pn && !prev_pn)) begin
      code_log[log_n % 64] <= ifc.dev_code;
      log_n <= log_n + 1;
    end
    if (ifc.ob_clear) clr_n <= clr_n + 1;
    if (word_done) wd_n <= wd_n + 1;
  end

  int s_twh, s_twr, s_pnh, s_pnr, s_clr, s_wd, s_log;

  task automatic snap();
    s_twh = tw_hi;  s_twr = tw_rise; s_pnh = pn_hi; s_pnr = pn_rise;
    s_clr = clr_n;  s_wd  = wd_n;    s_log = log_n;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic wait_req(input string tag);
    int i;
    i = 0;
    while (!ifc.char_req && i < 64) begin
      tick();
      i++;
    end
    chk(tag, ifc.char_req, 1);
  endtask

  task automatic wait_ready(input string tag);
    int i;
    i = 0;
    while (!ready && i < 64) begin
      tick();
      i++;
    end
    chk(tag, ready, 1);
  endtask

  // Answer the next char_req with one ack cycle carrying code.
  task automatic serve(input logic [4:0] code, input string tag);
    wait_req(tag);
    tick();
    ifc.char_ack = 1'b1;
    ifc.ob_code  = code;
    tick();
    ifc.char_ack = 1'b0;
    ifc.ob_code  = 5'b0;
  endtask

  task automatic do_start(input logic sel);
    dev_sel = sel;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"}, ready, 1);
    chk({pfx, "_req"}, ifc.char_req, 0);
    chk({pfx, "_clr"}, ifc.ob_clear, 0);
    chk({pfx, "_wd"}, word_done, 0);
    chk({pfx, "_err"}, err_timeout, 0);
    chk({pfx, "_tw"}, ifc.dev_strobe_tw, 0);
    chk({pfx, "_pn"}, ifc.dev_strobe_pn, 0);
    chk({pfx, "_code"}, ifc.dev_code, 0);
    chk({pfx, "_cnt"}, char_cnt, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; abort = 1'b0; dev_sel = 1'b0;
    ifc.char_ack = 1'b0; ifc.ob_code = 5'b0; ifc.dev_busy = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst0");
    rst = 1'b1;
    tick();

    // Two typewriter characters, then STOP.
    snap();
    do_start(1'b0);
    chk("t1_req_latency", ifc.char_req, 1);
    chk("t1_ready_low", ready, 0);
    serve(5'b00001, "t1_req1");
    chk("t1_tw_first", ifc.dev_strobe_tw, 1);
    chk("t1_cnt_first", char_cnt, 1);
    chk("t1_code1", ifc.dev_code, 5'b00001);
    serve(5'b00010, "t1_req2");
    serve(C_STOP, "t1_req3");
    chk("t1_word_done", word_done, 1);
    chk("t1_done_clr", ifc.ob_clear, 1);
    wait_ready("t1_ready");
    chk("t1_cnt", char_cnt, 2);
    chk("t1_tw_rises", tw_rise - s_twr, 2);
    chk("t1_tw_cycles", tw_hi - s_twh, 2 * STB);
    chk("t1_pn_cycles", pn_hi - s_pnh, 0);
    chk("t1_clr_pulses", clr_n - s_clr, 3);
    chk("t1_wd_pulses", wd_n - s_wd, 1);
    chk("t1_log0", code_log[s_log % 64], 5'b00001);
    chk("t1_log1", code_log[(s_log + 1) % 64], 5'b00010);

    // WAIT code between two characters; STOP with the don't-care bit set.
    snap();
    do_start(1'b0);
    serve(5'b00011, "t2_req1");
    serve(C_WAIT, "t2_req2");
    chk("t2_wait_no_strobe", ifc.dev_strobe_tw, 0);
    chk("t2_wait_clr", ifc.ob_clear, 1);
    chk("t2_wait_code", ifc.dev_code, C_WAIT);
    serve(5'b00101, "t2_req3");
    serve(C_STOP3, "t2_req4");
    chk("t2_word_done", word_done, 1);
    wait_ready("t2_ready");
    chk("t2_cnt", char_cnt, 2);
    chk("t2_tw_rises", tw_rise - s_twr, 2);
    chk("t2_clr_pulses", clr_n - s_clr, 4);
    chk("t2_log0", code_log[s_log % 64], 5'b00011);
    chk("t2_log1", code_log[(s_log + 1) % 64], 5'b00101);

    // Punch with a bouncing busy line; b4=1 makes the STOP pattern printable.
    snap();
    do_start(1'b1);
    serve(5'b10100, "t3_req1");
    chk("t3_pn_on", ifc.dev_strobe_pn, 1);
    chk("t3_tw_off", ifc.dev_strobe_tw, 0);
    ifc.dev_busy = 1'b1;
    n = 0;
    while (ifc.dev_strobe_pn && n < 16) begin
      tick();
      n++;
    end
    chk("t3_pn_width", n, STB);
    repeat (10) tick();
    ifc.dev_busy = 1'b0;
    tick();
    ifc.dev_busy = 1'b1;
    repeat (3) tick();
    chk("t3_no_req_bounce", ifc.char_req, 0);
    chk("t3_no_clr_bounce", ifc.ob_clear, 0);
    ifc.dev_busy = 1'b0;
    tick();
    n = 0;
    while (!ifc.char_req && n < 16) begin
      tick();
      n++;
    end
    chk("t3_req_after_busy", n, SET);
    serve(C_STOP, "t3_req2");
    wait_ready("t3_ready");
    chk("t3_cnt", char_cnt, 1);
    chk("t3_pn_rises", pn_rise - s_pnr, 1);
    chk("t3_pn_cycles", pn_hi - s_pnh, STB);
    chk("t3_tw_cycles", tw_hi - s_twh, 0);
    chk("t3_code", ifc.dev_code, C_STOP);

    // Ack timeout, then a start clears the sticky error.
    snap();
    do_start(1'b0);
    wait_req("t4_req");
    n = 0;
    while (!err_timeout && n < 1100) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", n, TMO);
    chk("t4_abort_clr", ifc.ob_clear, 1);
    chk("t4_not_ready", ready, 0);
    tick();
    chk("t4_ready", ready, 1);
    chk("t4_clr_off", ifc.ob_clear, 0);
    chk("t4_err_sticky", err_timeout, 1);
    tick();
    chk("t4_clr_pulses", clr_n - s_clr, 1);
    chk("t4_no_wd", wd_n - s_wd, 0);
    do_start(1'b0);
    chk("t4_err_cleared", err_timeout, 0);
    chk("t4_restart_req", ifc.char_req, 1);
    serve(C_STOP, "t4_req2");
    wait_ready("t4_ready2");

    // Ack arriving in the very last allowed cycle still counts.
    do_start(1'b0);
    wait_req("t4b_req");
    repeat (TMO - 1) tick();
    chk("t4b_no_err_yet", err_timeout, 0);
    ifc.char_ack = 1'b1;
    ifc.ob_code  = 5'b00001;
    tick();
    ifc.char_ack = 1'b0;
    ifc.ob_code  = 5'b0;
    chk("t4b_err", err_timeout, 0);
    chk("t4b_strobe", ifc.dev_strobe_tw, 1);
    serve(C_STOP, "t4b_req2");
    wait_ready("t4b_ready");

    // Abort on the second strobe cycle; start with abort in IDLE is ignored.
    snap();
    do_start(1'b0);
    serve(5'b00001, "t5_req1");
    tick();
    chk("t5_strobe2", ifc.dev_strobe_tw, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_strobe_drop", ifc.dev_strobe_tw, 0);
    chk("t5_abort_clr", ifc.ob_clear, 1);
    chk("t5_cnt_held", char_cnt, 1);
    chk("t5_err_held", err_timeout, 0);
    tick();
    chk("t5_ready", ready, 1);
    chk("t5_clr_off", ifc.ob_clear, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t5_start_ignored_rdy", ready, 1);
    chk("t5_start_ignored_req", ifc.char_req, 0);
    tick();
    chk("t5_still_idle", ifc.char_req, 0);
    chk("t5_clr_pulses", clr_n - s_clr, 1);
    chk("t5_tw_cycles", tw_hi - s_twh, 2);

    // Reset in the middle of a strobe.
    do_start(1'b0);
    serve(5'b00001, "t6_req0");
    chk("t6_tw_on", ifc.dev_strobe_tw, 1);
    rst = 1'b0;
    tick();
    chk_reset_vals("t6_rst_strobe");
    rst = 1'b1;
    tick();

    // Reset while waiting on a busy device after five characters.
    do_start(1'b0);
    serve(5'b01001, "t6_req1");
    serve(5'b01010, "t6_req2");
    serve(5'b01011, "t6_req3");
    serve(5'b01101, "t6_req4");
    serve(5'b01110, "t6_req5");
    ifc.dev_busy = 1'b1;
    repeat (STB) tick();
    chk("t6_in_waitdev_tw", ifc.dev_strobe_tw, 0);
    chk("t6_cnt5", char_cnt, 5);
    tick();
    rst = 1'b0;
    tick();
    chk_reset_vals("t6_rst_waitdev");
    rst = 1'b1;
    ifc.dev_busy = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/io_slow_out_seq.md
Name: io_slow_out_seq

Overview:
- Sequences character-by-character slow output (typewriter / tape punch) through the I/O OB character register.
- Each cycle it requests a character from the OA/OB datapath, decodes special codes (STOP, WAIT), strobes the selected device and honours its busy handshake.
- It clears OB between characters and returns to READY.
- Sits between the I/O 3/4 register logic and the external device adapters.

Parameters:
- STROBE_CYCLES, 4: cycles dev_strobe is held high per character (≥1).
- SETTLE_CYCLES, 2: consecutive cycles dev_busy must be low before the next character (≥1).
- TIMEOUT, 1024: cycles allowed between char_req and char_ack before abort (≥2).

Ports:
- CLOCK  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  begin output of one word; sampled only in IDLE.
- abort  in  1  synchronous abort; highest priority after reset.
- dev_sel  in  1  0 = typewriter, 1 = tape punch; latched at start.
- char_req  out  1  one-cycle pulse: datapath forms next character in OB.
- char_ack  in  1  OB code valid this cycle.
- ob_code  in  5  {OB5,OB4,OB3,OB2,OB1}.
- dev_code  out  5  latched character presented to device.
- dev_strobe_tw  out  1  typewriter strobe.
- dev_strobe_pn  out  1  punch strobe.
- dev_busy  in  1  selected device busy.
- ob_clear  out  1  one-cycle OB clear pulse.
- ready  out  1  high in IDLE.
- word_done  out  1  one-cycle pulse when STOP code terminates the word.
- err_timeout  out  1  sticky; set on char_ack timeout, cleared by start or reset.
- char_cnt  out  6  characters strobed since start, wraps mod 64.

Behaviour:
- Reset (rst=0 at clock edge) values:
  - state IDLE, ready=1.
  - All other outputs 0, dev_code=0, char_cnt=0, dev_sel latch=0.
- Code decode (on ob_code at char_ack):
  - STOP: b4=0, b2=1, b1:0=00.
  - WAIT: b4=0, b2:0=111.
  - Else: printable.
- IDLE:
  - ready=1.
  - start & ~abort → REQ. Latch dev_sel, clear char_cnt and err_timeout.
- REQ:
  - char_req=1 for exactly one cycle; load timer with TIMEOUT.
  - → WAIT_ACK.
- WAIT_ACK:
  - char_ack → latch dev_code=ob_code, then:
    - STOP → DONE.
    - WAIT → CLEAR (no strobe, char_cnt unchanged).
    - Else → STROBE.
  - Timer decrements each cycle without ack. At expiry with no ack: set err_timeout, → CLEAR_ABORT.
  - char_ack in the expiry cycle wins (no error).
- STROBE:
  - Strobe of the latched device high for exactly STROBE_CYCLES cycles; the other strobe stays 0.
  - char_cnt increments by 1 on the first strobe cycle.
  - → WAIT_DEV.
- WAIT_DEV:
  - Count consecutive cycles with dev_busy=0; any dev_busy=1 restarts the count.
  - After SETTLE_CYCLES consecutive low cycles → CLEAR.
- CLEAR:
  - ob_clear=1 for one cycle → REQ.
- DONE:
  - ob_clear=1 and word_done=1 for one cycle → IDLE.
- CLEAR_ABORT:
  - ob_clear=1 for one cycle → IDLE.
- Latency:
  - start at edge N → char_req high cycle N+1.
  - char_ack at cycle M → strobe high cycles M+1 .. M+STROBE_CYCLES.
- abort = 1 in any non-IDLE state:
  - Next cycle state is CLEAR_ABORT.
  - Strobes drop that same next cycle.
  - char_cnt and err_timeout are held.
- abort in IDLE: no effect; start is ignored that cycle.
- start outside IDLE: ignored.
- Reset mid-strobe: strobes drop at the reset edge.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package io_seq_pkg holds:
  - The state enum (IDLE, REQ, WAIT_ACK, STROBE, WAIT_DEV, CLEAR, DONE, CLEAR_ABORT).
  - OB code mask/value constants for STOP and WAIT.
  - A function is_stop/is_wait.
- Sub-module io_cycle_timer:
  - Loadable down-counter, width $clog2(max(TIMEOUT, STROBE_CYCLES, SETTLE_CYCLES)+1).
  - Ports: load, value, en, expired.
  - One instance shared for strobe, settle and timeout; the FSM reloads it on each state entry.

Test Plan:
- Reset, start, acks 5'b00001, 5'b00010, then STOP 5'b00100; dev_sel=0, dev_busy always 0:
  - dev_strobe_tw pulses twice, each 4 cycles wide.
  - dev_code 01 then 02.
  - char_cnt=2, word_done once, ob_clear pulses ×3, ready returns.
- Ack WAIT 5'b00111 between two digits:
  - No strobe for the WAIT character.
  - char_cnt=2, ob_clear still pulses for it.
- dev_sel=1; dev_busy high 10 cycles after the strobe, low 1 cycle, high 3 cycles, then low:
  - Next char_req exactly 2 cycles after the final busy fall.
  - Only dev_strobe_pn toggles.
- No char_ack for 1024 cycles:
  - err_timeout=1, one ob_clear, ready=1.
  - A following start clears err_timeout.
- abort asserted on the 2nd strobe cycle:
  - Strobe low next cycle, then one ob_clear cycle, then ready.
  - A start in the same cycle as abort while IDLE is ignored.
- rst=0 while in WAIT_DEV with char_cnt=5:
  - All outputs return to reset values at that edge; ready=1, char_cnt=0.
